// File: rtl/lzs_pkg.sv
// Shared definitions for the LZS compression unit: datapath widths,
// descriptor control bit positions and the common job state encoding.
package lzs_pkg;

    localparam int HW_W        = 16;
    localparam int WORD_W      = 64;
    localparam int HW_PER_WORD = 4;

    localparam int DC_ENC = 5;
    localparam int DC_DEC = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/codein_word_slot.sv
// One buffered source word with its last flag and valid bit.
// Clear wins over load so a job flush always empties the slot.
module word_slot
    import lzs_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_last,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_word;
    logic              r_last;
    logic              r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end
    end

    assign o_word  = r_word;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

// File: rtl/codein.sv
// Source-side unpacker: pops 64-bit words from the source FIFO and streams
// them most-significant halfword first to the LZS engine with valid/ready.
module codein
    import lzs_pkg::*;
(
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              m_enable,
    input  logic [23:0]       dc,
    output logic              m_src_getn,
    input  logic [WORD_W-1:0] m_src,
    input  logic              m_src_last,
    input  logic              m_src_almost_empty,
    input  logic              m_src_empty,
    output logic [HW_W-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done_o
);

    state_t r_state;
    state_t w_stateNext;

    logic       r_getn;
    logic       r_inFlight;
    logic       r_lastSeen;
    logic       r_done;
    logic [1:0] r_hidx;

    logic [WORD_W-1:0] w_holdWord;
    logic [WORD_W-1:0] w_pendWord;
    logic [WORD_W-1:0] w_holdIn;
    logic              w_holdLast;
    logic              w_pendLast;
    logic              w_holdLastIn;
    logic              w_holdValid;
    logic              w_pendValid;

    logic w_active;
    logic w_accept;
    logic w_wrap;
    logic w_ret;
    logic w_holdLoadPend;
    logic w_holdLoadRet;
    logic w_holdLoad;
    logic w_holdClear;
    logic w_pendLoad;
    logic w_pendClear;
    logic w_pendValidNext;
    logic w_popNext;
    logic w_doneNext;

    logic [21:0] w_unusedDc;

    assign w_unusedDc = {dc[23:DC_DEC+1], dc[DC_ENC-1:0]};
    assign w_active   = m_enable && (dc[DC_ENC] || dc[DC_DEC]);
    assign w_accept   = w_holdValid && out_ready;
    assign w_wrap     = w_accept && (r_hidx == 2'(HW_PER_WORD - 1));
    assign w_ret      = r_inFlight && m_enable;

    // A returning word goes to holding when it is empty or finishing its last
    // halfword without a pending successor; otherwise it parks in pending.
    assign w_holdLoadPend  = w_wrap && w_pendValid;
    assign w_holdLoadRet   = w_ret && (!w_holdValid || (w_wrap && !w_pendValid));
    assign w_holdLoad      = w_holdLoadPend || w_holdLoadRet;
    assign w_holdIn        = w_holdLoadPend ? w_pendWord : m_src;
    assign w_holdLastIn    = w_holdLoadPend ? w_pendLast : m_src_last;
    assign w_holdClear     = !m_enable || (w_wrap && !w_holdLoad);
    assign w_pendLoad      = w_ret && !w_holdLoadRet;
    assign w_pendClear     = !m_enable || (w_holdLoadPend && !w_pendLoad);
    assign w_pendValidNext = m_enable && (w_pendLoad || (w_pendValid && !w_holdLoadPend));

    word_slot u_hold (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_clear (w_holdClear),
        .i_load  (w_holdLoad),
        .i_word  (w_holdIn),
        .i_last  (w_holdLastIn),
        .o_word  (w_holdWord),
        .o_last  (w_holdLast),
        .o_valid (w_holdValid)
    );

    word_slot u_pend (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_clear (w_pendClear),
        .i_load  (w_pendLoad),
        .i_word  (m_src),
        .i_last  (m_src_last),
        .o_word  (w_pendWord),
        .o_last  (w_pendLast),
        .o_valid (w_pendValid)
    );

    always_comb begin
        w_stateNext = r_state;
        w_doneNext  = 1'b0;
        if (!m_enable) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_active) begin
                        w_stateNext = RUN;
                    end
                end
                RUN: begin
                    if (w_accept && out_last) begin
                        w_stateNext = DONE;
                        w_doneNext  = 1'b1;
                    end
                end
                DONE: begin
                    w_stateNext = DONE;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // The pop strobe is registered, so the decision is made one cycle early
    // against next-cycle state; the almost-empty guard covers the flag lag
    // of a pop that is still being retired by the FIFO.
    assign w_popNext = (w_stateNext == RUN)
                    && !m_src_empty
                    && r_getn
                    && !(m_src_almost_empty && r_inFlight)
                    && !w_pendValidNext
                    && !r_lastSeen
                    && !(w_ret && m_src_last);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= IDLE;
            r_getn     <= 1'b1;
            r_inFlight <= 1'b0;
            r_lastSeen <= 1'b0;
            r_done     <= 1'b0;
            r_hidx     <= 2'd0;
        end else begin
            r_state    <= w_stateNext;
            r_getn     <= !w_popNext;
            r_inFlight <= m_enable && !r_getn;
            r_lastSeen <= m_enable && (r_lastSeen || (w_ret && m_src_last));
            r_done     <= w_doneNext;
            if (!m_enable) begin
                r_hidx <= 2'd0;
            end else if (w_accept) begin
                r_hidx <= r_hidx + 2'd1;
            end
        end
    end

    always_comb begin
        out_data = w_holdWord[63:48];
        case (r_hidx)
            2'd0:    out_data = w_holdWord[63:48];
            2'd1:    out_data = w_holdWord[47:32];
            2'd2:    out_data = w_holdWord[31:16];
            2'd3:    out_data = w_holdWord[15:0];
            default: out_data = w_holdWord[63:48];
        endcase
    end

    assign out_last   = w_holdLast && (r_hidx == 2'(HW_PER_WORD - 1));
    assign out_valid  = w_holdValid;
    assign m_src_getn = r_getn;
    assign done_o     = r_done;

endmodule

// File: tb/tb_codein.sv
// Self-checking bench for codein: a behavioural source FIFO feeds the DUT and
// accepted halfwords are compared against word-to-halfword expectations.
module tb_codein;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b1;
    logic        m_enable = 1'b0;
    logic [23:0] dc = '0;
    logic        m_src_getn;
    logic [63:0] m_src = '0;
    logic        m_src_last = 1'b0;
    logic        m_src_almost_empty;
    logic        m_src_empty;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        done_o;

    int errors = 0;
    int checks = 0;

    logic [64:0] fifoQ[$];
    int          fifoCount = 0;
    int          popCount = 0;
    int          underflow = 0;
    int          popCyc[$];
    logic        doPop;
    logic [64:0] ent;

    int          cyc = 0;
    logic [15:0] obsData[$];
    logic        obsLast[$];
    int          obsCyc[$];
    int          doneCount = 0;
    int          doneCyc = -1;
    int          stallViol = 0;
    logic        prevStall = 1'b0;
    logic [15:0] prevData = '0;

    logic [15:0] expD[$];
    logic        expL[$];

    codein dut (
        .wb_clk_i           (wb_clk_i),
        .wb_rst_ni          (wb_rst_ni),
        .m_enable           (m_enable),
        .dc                 (dc),
        .m_src_getn         (m_src_getn),
        .m_src              (m_src),
        .m_src_last         (m_src_last),
        .m_src_almost_empty (m_src_almost_empty),
        .m_src_empty        (m_src_empty),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .done_o             (done_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    assign m_src_empty        = (fifoCount == 0);
    assign m_src_almost_empty = (fifoCount <= 1);

    // Source FIFO model: one-cycle read latency, flags refreshed mid-cycle.
    always begin
        @(posedge wb_clk_i);
        doPop = (m_src_getn == 1'b0);
        #1;
        if (doPop) begin
            if (fifoQ.size() == 0) begin
                underflow++;
            end else begin
                ent        = fifoQ.pop_front();
                m_src      = ent[63:0];
                m_src_last = ent[64];
                popCount++;
                popCyc.push_back(cyc);
            end
        end
        @(negedge wb_clk_i);
        fifoCount = fifoQ.size();
    end

    // Observe the engine side on the falling edge, ahead of the handshake edge.
    always @(negedge wb_clk_i) begin
        cyc++;
        if (wb_rst_ni && prevStall && (!out_valid || out_data !== prevData)) begin
            stallViol++;
        end
        prevStall = wb_rst_ni && m_enable && out_valid && !out_ready;
        prevData  = out_data;
        if (wb_rst_ni && out_valid && out_ready) begin
            obsData.push_back(out_data);
            obsLast.push_back(out_last);
            obsCyc.push_back(cyc);
        end
        if (done_o) begin
            doneCount++;
            doneCyc = cyc;
        end
    end

    task automatic addExpected(input logic [63:0] w, input logic last);
        logic [63:0] sh;
        for (int k = 0; k < 4; k++) begin
            sh = w >> (48 - 16 * k);
            expD.push_back(sh[15:0]);
            expL.push_back(last && (k == 3));
        end
    endtask

    task automatic applyStimulus(input int nCycles);
        for (int i = 0; i < nCycles; i++) begin
            @(posedge wb_clk_i);
            #2;
        end
    endtask

    task automatic startJob(input logic useDecode);
        @(posedge wb_clk_i);
        #2;
        dc       = useDecode ? 24'h000040 : 24'h000020;
        m_enable = 1'b1;
    endtask

    task automatic stopJob();
        @(posedge wb_clk_i);
        #2;
        m_enable = 1'b0;
        applyStimulus(2);
        fifoQ.delete();
        expD.delete();
        expL.delete();
    endtask

    task automatic waitDone(input int startDone, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge wb_clk_i);
            #1;
            if (doneCount > startDone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 wb_rst_ni = 1'b0;
        #1;
        checks++; if (m_src_getn !== 1'b1) begin errors++; $display("[TB] FAIL reset_getn got=%b want=1", m_src_getn); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got=%b want=0", out_last); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_data got=%h want=0000", out_data); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done_o); end
        applyStimulus(2);
        wb_rst_ni = 1'b1;
        applyStimulus(2);
        checks++; if (m_src_getn !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset getn=%b valid=%b want getn=1 valid=0", m_src_getn, out_valid); end
    endtask

    task automatic test_single_word();
        int  b, pb, db, pc;
        bit  ok;
        expD.delete(); expL.delete();
        fifoQ.push_back({1'b1, 64'h0011_2233_4455_6677});
        addExpected(64'h0011_2233_4455_6677, 1'b1);
        b = obsData.size(); pb = popCyc.size(); db = doneCount;
        out_ready = 1'b1;
        startJob(1'b0);
        waitDone(db, 60, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_done_timeout got=none want=pulse"); end
        applyStimulus(3);
        checks++; if (obsData.size() - b != 4) begin errors++; $display("[TB] FAIL single_count got=%0d want=4", obsData.size() - b); end
        if (obsData.size() - b >= 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (obsData[b+k] !== expD[k] || obsLast[b+k] !== expL[k]) begin errors++; $display("[TB] FAIL single_hw%0d got=%h/%b want=%h/%b", k, obsData[b+k], obsLast[b+k], expD[k], expL[k]); end
            end
            checks++; if (obsCyc[b+3] - obsCyc[b] != 3) begin errors++; $display("[TB] FAIL single_consecutive got=%0d want=3", obsCyc[b+3] - obsCyc[b]); end
            checks++; if (popCyc.size() <= pb || obsCyc[b] - popCyc[pb] != 2) begin errors++; $display("[TB] FAIL single_latency got=%0d want=2", (popCyc.size() > pb) ? obsCyc[b] - popCyc[pb] : -1); end
            checks++; if (doneCyc != obsCyc[b+3] + 1) begin errors++; $display("[TB] FAIL single_done_cycle got=%0d want=%0d", doneCyc, obsCyc[b+3] + 1); end
        end
        checks++; if (doneCount - db != 1) begin errors++; $display("[TB] FAIL single_done_pulses got=%0d want=1", doneCount - db); end
        pc = popCount;
        fifoQ.push_back({1'b0, 64'hDEAD_BEEF_0BAD_F00D});
        applyStimulus(6);
        checks++; if (popCount != pc) begin errors++; $display("[TB] FAIL done_no_pop got=%0d want=%0d", popCount, pc); end
        stopJob();
    endtask

    task automatic test_streaming();
        int          b, pc, db;
        bit          ok;
        logic [63:0] w;
        expD.delete(); expL.delete();
        for (int i = 0; i < 9; i++) begin
            w = {$urandom, $urandom};
            fifoQ.push_back({(i == 7), w});
            if (i < 8) addExpected(w, (i == 7));
        end
        b = obsData.size(); pc = popCount; db = doneCount;
        out_ready = 1'b1;
        startJob(1'b1);
        waitDone(db, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stream_done_timeout got=none want=pulse"); end
        applyStimulus(6);
        checks++; if (obsData.size() - b != 32) begin errors++; $display("[TB] FAIL stream_count got=%0d want=32", obsData.size() - b); end
        if (obsData.size() - b >= 32) begin
            for (int k = 0; k < 32; k++) begin
                checks++; if (obsData[b+k] !== expD[k] || obsLast[b+k] !== expL[k]) begin errors++; $display("[TB] FAIL stream_hw%0d got=%h/%b want=%h/%b", k, obsData[b+k], obsLast[b+k], expD[k], expL[k]); end
            end
            checks++; if (obsCyc[b+31] - obsCyc[b] != 31) begin errors++; $display("[TB] FAIL stream_gapless got=%0d want=31", obsCyc[b+31] - obsCyc[b]); end
        end
        checks++; if (popCount - pc != 8) begin errors++; $display("[TB] FAIL stream_pops got=%0d want=8", popCount - pc); end
        checks++; if (fifoQ.size() != 1) begin errors++; $display("[TB] FAIL stream_left_in_fifo got=%0d want=1", fifoQ.size()); end
        stopJob();
    endtask

    task automatic test_backpressure();
        int          b, pc, db, sv, uf;
        bit          ok;
        logic [63:0] w;
        expD.delete(); expL.delete();
        for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom};
            fifoQ.push_back({(i == 4), w});
            addExpected(w, (i == 4));
        end
        b = obsData.size(); pc = popCount; db = doneCount; sv = stallViol; uf = underflow;
        out_ready = 1'b0;
        startJob(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge wb_clk_i);
            #2;
            out_ready = 1'($urandom_range(0, 1));
            if (doneCount > db) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        applyStimulus(3);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done_timeout got=none want=pulse"); end
        checks++; if (obsData.size() - b != 20) begin errors++; $display("[TB] FAIL bp_count got=%0d want=20", obsData.size() - b); end
        if (obsData.size() - b >= 20) begin
            for (int k = 0; k < 20; k++) begin
                checks++; if (obsData[b+k] !== expD[k] || obsLast[b+k] !== expL[k]) begin errors++; $display("[TB] FAIL bp_hw%0d got=%h/%b want=%h/%b", k, obsData[b+k], obsLast[b+k], expD[k], expL[k]); end
            end
        end
        checks++; if (stallViol != sv) begin errors++; $display("[TB] FAIL bp_stall_stable got=%0d want=%0d", stallViol, sv); end
        checks++; if (popCount - pc != 5 || underflow != uf) begin errors++; $display("[TB] FAIL bp_pops got=%0d/%0d want=5/0", popCount - pc, underflow - uf); end
        stopJob();
    endtask

    task automatic test_flag_lag();
        int          b, pc, pb, uf, db;
        bit          ok;
        logic [63:0] w0, w1;
        expD.delete(); expL.delete();
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        fifoQ.push_back({1'b0, w0});
        addExpected(w0, 1'b0);
        b = obsData.size(); pc = popCount; pb = popCyc.size(); uf = underflow; db = doneCount;
        out_ready = 1'b1;
        startJob(1'b1);
        applyStimulus(12);
        checks++; if (popCount - pc != 1 || underflow != uf) begin errors++; $display("[TB] FAIL lag_single_pop got=%0d/%0d want=1/0", popCount - pc, underflow - uf); end
        checks++; if (out_valid !== 1'b0 || obsData.size() - b != 4) begin errors++; $display("[TB] FAIL lag_drained valid=%b count=%0d want valid=0 count=4", out_valid, obsData.size() - b); end
        fifoQ.push_back({1'b1, w1});
        addExpected(w1, 1'b1);
        waitDone(db, 40, ok);
        applyStimulus(2);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL lag_done_timeout got=none want=pulse"); end
        checks++; if (obsData.size() - b != 8) begin errors++; $display("[TB] FAIL lag_count got=%0d want=8", obsData.size() - b); end
        if (obsData.size() - b >= 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++; if (obsData[b+k] !== expD[k] || obsLast[b+k] !== expL[k]) begin errors++; $display("[TB] FAIL lag_hw%0d got=%h/%b want=%h/%b", k, obsData[b+k], obsLast[b+k], expD[k], expL[k]); end
            end
            checks++; if (popCyc.size() < pb + 2 || obsCyc[b+4] - popCyc[pb+1] != 2) begin errors++; $display("[TB] FAIL lag_resume_latency got=%0d want=2", (popCyc.size() >= pb + 2) ? obsCyc[b+4] - popCyc[pb+1] : -1); end
        end
        checks++; if (popCount - pc != 2) begin errors++; $display("[TB] FAIL lag_pops got=%0d want=2", popCount - pc); end
        stopJob();
    endtask

    task automatic test_disable();
        int          b, db, n;
        bit          ok, found;
        logic [63:0] w[4];
        logic [64:0] e;
        expD.delete(); expL.delete();
        for (int i = 0; i < 4; i++) begin
            w[i] = {$urandom, $urandom};
            fifoQ.push_back({(i == 3), w[i]});
        end
        out_ready = 1'b1;
        startJob(1'b0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge wb_clk_i);
            #1;
            if (out_valid && out_data == w[0][31:16]) begin
                m_enable = 1'b0;
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL dis_reach_hidx2 got=none want=%h", w[0][31:16]); end
        @(negedge wb_clk_i);
        #1;
        checks++; if (out_valid !== 1'b0 || m_src_getn !== 1'b1) begin errors++; $display("[TB] FAIL dis_flush valid=%b getn=%b want valid=0 getn=1", out_valid, m_src_getn); end
        applyStimulus(3);
        n = fifoQ.size();
        for (int i = 0; i < n; i++) begin
            e = fifoQ[i];
            addExpected(e[63:0], e[64]);
        end
        checks++; if (n < 1) begin errors++; $display("[TB] FAIL dis_words_left got=%0d want>=1", n); end
        b = obsData.size(); db = doneCount;
        startJob(1'b0);
        waitDone(db, 120, ok);
        applyStimulus(2);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL dis_restart_done got=none want=pulse"); end
        checks++; if (obsData.size() - b != 4 * n) begin errors++; $display("[TB] FAIL dis_restart_count got=%0d want=%0d", obsData.size() - b, 4 * n); end
        if (obsData.size() - b >= 4 * n) begin
            for (int k = 0; k < 4 * n; k++) begin
                checks++; if (obsData[b+k] !== expD[k] || obsLast[b+k] !== expL[k]) begin errors++; $display("[TB] FAIL dis_hw%0d got=%h/%b want=%h/%b", k, obsData[b+k], obsLast[b+k], expD[k], expL[k]); end
            end
        end
        stopJob();
    endtask

    task automatic test_async_reset();
        logic [63:0] w;
        for (int i = 0; i < 4; i++) begin
            w = {$urandom, $urandom};
            fifoQ.push_back({(i == 3), w});
        end
        out_ready = 1'b1;
        startJob(1'b1);
        applyStimulus(7);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_streaming got=%b want=1", out_valid); end
        wb_rst_ni = 1'b0;
        #1;
        checks++; if (m_src_getn !== 1'b1 || out_valid !== 1'b0 || done_o !== 1'b0 || out_data !== 16'h0) begin errors++; $display("[TB] FAIL ar_immediate getn=%b valid=%b done=%b data=%h want 1/0/0/0000", m_src_getn, out_valid, done_o, out_data); end
        m_enable = 1'b0;
        @(negedge wb_clk_i);
        #2;
        wb_rst_ni = 1'b1;
        #1;
        checks++; if (m_src_getn !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL ar_released getn=%b valid=%b last=%b want 1/0/0", m_src_getn, out_valid, out_last); end
        applyStimulus(2);
        checks++; if (m_src_getn !== 1'b1 || out_valid !== 1'b0 || done_o !== 1'b0) begin errors++; $display("[TB] FAIL ar_idle getn=%b valid=%b done=%b want 1/0/0", m_src_getn, out_valid, done_o); end
        stopJob();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_flag_lag();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
